hilo_div_unit: RTL and testbench

//  Iterative radix-2 restoring divider that produces the 64-bit HI/LO write for the register file.

---
 rtl/hilo_div_unit.sv | 157 +++++++++++++++
 tb/tb_hilo_div_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: iterative radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} as the HI/LO register-file write, with a
// one-cycle hl_write_enable pulse on completion.
// Optional build macro: HILO_DIV_EARLY_EN (early exit when |dividend| < |divisor|).
module hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic [2*WIDTH-1:0] hl_data,
    output logic               hl_write_enable
);

    // state | meaning
    // IDLE  | waiting for start
    // PREP  | form operand magnitudes and sign flags
    // ITER  | one shift/subtract step per cycle, WIDTH steps
    // FIX   | apply signs / special cases, register result
    // DONE  | write pulse cycle; accepts a new start like IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_raw, dvs_raw;
    logic             sgn_raw;
    logic [WIDTH-1:0] quo, rem, dvs_abs;
    logic             neg_q, neg_r, early;

    logic             accept;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             early_hit;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic [2*WIDTH-1:0] result;

    assign busy   = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
    assign accept = ((state == S_IDLE) || (state == S_DONE)) && start && !flush;

    // Operand magnitudes from the sampled raw values
    always_comb begin
        dvd_mag = dvd_raw;
        dvs_mag = dvs_raw;
        if (sgn_raw && dvd_raw[WIDTH-1]) dvd_mag = (~dvd_raw) + WIDTH'(1);
        if (sgn_raw && dvs_raw[WIDTH-1]) dvs_mag = (~dvs_raw) + WIDTH'(1);
    end

    // Early-exit decision, only present in the early-exit build
    always_comb begin
        early_hit = 1'b0;
`ifdef HILO_DIV_EARLY_EN
        early_hit = (dvs_raw != '0) && (dvd_mag < dvs_mag);
`endif
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so after the shift it is below 2*divisor: bit WIDTH of the difference
    // is a clean borrow flag and the kept remainder fits in WIDTH bits.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvs_abs};
        rem_ge   = ~rem_diff[WIDTH];
    end

    // Final sign application and special-case results
    always_comb begin
        quo_fix = neg_q ? (~quo) + WIDTH'(1) : quo;
        rem_fix = neg_r ? (~rem) + WIDTH'(1) : rem;
        if (dvs_raw == '0)
            result = {dvd_raw, {WIDTH{1'b1}}};
        else if (early)
            result = {dvd_raw, {WIDTH{1'b0}}};
        else
            result = {rem_fix, quo_fix};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; flush overrides everything but reset
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = accept ? S_PREP : S_IDLE;
            S_PREP:         state_nx = early_hit ? S_FIX : S_ITER;
            S_ITER:         state_nx = (cnt == CW'(WIDTH - 1)) ? S_FIX : S_ITER;
            S_FIX:          state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    // Datapath: operand capture, iteration, result register and write pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            dvd_raw         <= '0;
            dvs_raw         <= '0;
            sgn_raw         <= 1'b0;
            quo             <= '0;
            rem             <= '0;
            dvs_abs         <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            early           <= 1'b0;
            hl_data         <= '0;
            hl_write_enable <= 1'b0;
        end else begin
            hl_write_enable <= (state == S_FIX) && !flush;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        dvd_raw <= dividend;
                        dvs_raw <= divisor;
                        sgn_raw <= is_signed;
                    end
                end
                S_PREP: begin
                    quo     <= dvd_mag;
                    rem     <= '0;
                    dvs_abs <= dvs_mag;
                    neg_q   <= sgn_raw && (dvd_raw[WIDTH-1] ^ dvs_raw[WIDTH-1]);
                    neg_r   <= sgn_raw && dvd_raw[WIDTH-1];
                    early   <= early_hit;
                    cnt     <= '0;
                end
                S_ITER: begin
                    rem <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], rem_ge};
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    if (!flush) hl_data <= result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit (default build, WIDTH=32).
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst, flush, start, is_signed;
    logic [31:0] dividend, divisor;
    logic        busy, hl_write_enable;
    logic [63:0] hl_data;

    int checks = 0;
    int errors = 0;

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start),
        .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
        .busy(busy), .hl_data(hl_data), .hl_write_enable(hl_write_enable)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division with MIPS-style special cases
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            uq = q[31:0];
            ur = r[31:0];
        end else begin
            uq = a / b;
            ur = a % b;
        end
        return {ur, uq};
    endfunction

    // Drive one start, sampled at the next edge (edge k); returns at k+#1
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        is_signed = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom;
    endtask

    // Wait (bounded) for the write pulse; n = edges after edge k, busy_gap set
    // if busy dropped before the pulse
    task automatic wait_pulse(output int n, output logic busy_gap);
        n = 0; busy_gap = 1'b0;
        while (!hl_write_enable && n < 60) begin
            if (!busy) busy_gap = 1'b1;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; start = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || hl_write_enable !== 1'b0 || hl_data !== 64'd0) begin
            errors++;
            $display("FAIL reset busy=%b we=%b data=%h required 0/0/0", busy, hl_write_enable, hl_data);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234, 32'h8000_0000, 32'd0};
        logic [31:0] vb [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd5};
        logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [63:0] ve [6] = '{64'h0000_0002_0000_000E, 64'hFFFF_FFFF_FFFF_FFFD,
                                64'h0000_0001_FFFF_FFFD, 64'h0000_1234_FFFF_FFFF,
                                64'h0000_0000_8000_0000, 64'h0};
        int n; logic gap;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (busy !== 1'b1 && i < 0) errors++;
            issue(vs[i], va[i], vb[i]);
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_start[%0d] got %b required 1", i, busy);
            end
            wait_pulse(n, gap);
            checks++;
            if (n !== 34 || gap !== 1'b0) begin
                errors++;
                $display("FAIL latency[%0d] got %0d gap=%b required 34 gap=0", i, n, gap);
            end
            checks++;
            if (hl_data !== ve[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL directed[%0d] got %h busy=%b required %h busy=0", i, hl_data, busy, ve[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (hl_write_enable !== 1'b0 || hl_data !== ve[i]) begin
                errors++;
                $display("FAIL pulse_width[%0d] we=%b data=%h required 0 %h", i, hl_write_enable, hl_data, ve[i]);
            end
        end
    endtask

    task automatic test_random();
        int n; logic gap; logic s; logic [31:0] a, b; logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = (i % 5 == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            exp = ref_div(s, a, b);
            issue(s, a, b);
            wait_pulse(n, gap);
            checks++;
            if (n !== 34 || hl_data !== exp) begin
                errors++;
                $display("FAIL random[%0d] s=%b %h/%h got %h n=%0d required %h n=34", i, s, a, b, hl_data, n, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        int n; logic gap; logic [63:0] old; int pulses;
        old = hl_data;
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy got %b required 0", busy);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (hl_write_enable) pulses++;
        end
        checks++;
        if (pulses !== 0 || hl_data !== old) begin
            errors++;
            $display("FAIL flush_nopulse pulses=%0d data=%h required 0 %h", pulses, hl_data, old);
        end
        // flush beats start in the same cycle
        is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_beats_start busy=%b required 0", busy);
        end
        issue(1'b0, 32'd9, 32'd3);
        wait_pulse(n, gap);
        checks++;
        if (n !== 34 || hl_data !== 64'h0000_0000_0000_0003) begin
            errors++;
            $display("FAIL flush_restart got %h n=%0d required 0000000000000003 n=34", hl_data, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int n; logic gap; int pulses;
        issue(1'b0, 32'd77, 32'd10);
        repeat (4) @(posedge clk);
        #1 is_signed = 1'b1; dividend = 32'd5; divisor = 32'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        wait_pulse(n, gap);
        checks++;
        if (n !== 29 || hl_data !== ref_div(1'b0, 32'd77, 32'd10)) begin
            errors++;
            $display("FAIL busy_ignore got %h n=%0d required %h n=29", hl_data, n, ref_div(1'b0, 32'd77, 32'd10));
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (hl_write_enable) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL busy_ignore_extra pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2; logic gap;
        issue(1'b1, 32'hFFFF_FF00, 32'd7);
        wait_pulse(n1, gap);
        checks++;
        if (n1 !== 34 || hl_data !== ref_div(1'b1, 32'hFFFF_FF00, 32'd7)) begin
            errors++;
            $display("FAIL b2b_first got %h n=%0d required %h n=34", hl_data, n1, ref_div(1'b1, 32'hFFFF_FF00, 32'd7));
        end
        issue(1'b0, 32'hDEAD_BEEF, 32'd16);
        wait_pulse(n2, gap);
        checks++;
        if (n2 + 1 !== 35 || hl_data !== ref_div(1'b0, 32'hDEAD_BEEF, 32'd16)) begin
            errors++;
            $display("FAIL b2b_second got %h spacing=%0d required %h spacing=35", hl_data, n2 + 1, ref_div(1'b0, 32'hDEAD_BEEF, 32'd16));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int pulses;
        issue(1'b0, 32'd123, 32'd4);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || hl_write_enable !== 1'b0 || hl_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_abort busy=%b we=%b data=%h required 0/0/0", busy, hl_write_enable, hl_data);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (hl_write_enable) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_abort_pulse pulses=%0d required 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
